// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers.
//   - default bundle and statistics-counter widths
//   - occupancy state encoding of the stage register
//   - EX/MEM control bit indices and data packing offsets
package pipe_pkg;

  localparam int PIPE_CTRL_W = 8;
  localparam int PIPE_DATA_W = 96;
  localparam int PIPE_CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL1 = 2'd1,
    ST_FULL2 = 2'd2
  } occ_state_t;

  // EX/MEM control bundle bit positions (bit 7 spare)
  localparam int CTRL_REGWRITE  = 0;
  localparam int CTRL_MEMTOREG  = 1;
  localparam int CTRL_BRANCH    = 2;
  localparam int CTRL_MEMWR_LSB = 3;  // CTRL_MEMWR[1:0] = ctrl[4:3]
  localparam int CTRL_MEMRD_LSB = 5;  // CTRL_MEMRD[1:0] = ctrl[6:5]

  // EX/MEM data bundle packing; pc is carried as a word address
  localparam int DATA_ALUOUT_OFS = 0;
  localparam int DATA_ALUOUT_W   = 32;
  localparam int DATA_BUSB_OFS   = 32;
  localparam int DATA_BUSB_W     = 32;
  localparam int DATA_PC_OFS     = 64;
  localparam int DATA_PC_W       = 27;
  localparam int DATA_RD_OFS     = 91;
  localparam int DATA_RD_W       = 5;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for stage statistics.
//   clk, reset : clock, synchronous active-high reset (count -> 0)
//   clear      : synchronous clear
//   inc        : count up by one this cycle, holding at all-ones
//   count      : current value
module sat_counter
  import pipe_pkg::*;
#(
  parameter int CNT_W = PIPE_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Parametrised pipeline stage register with valid/ready handshake,
// flush-to-bubble and optional 1-entry skid buffer.
//   clk, reset           : clock, synchronous active-high reset
//   flush                : discard all held entries this edge
//   in_valid/in_ready    : upstream handshake; in_ctrl/in_data bundles
//   out_valid/out_ready  : downstream handshake; out_ctrl/out_data bundles
//   bubble_cnt/stall_cnt : saturating statistics counters
//
// state    | meaning
// ST_EMPTY | no entry held
// ST_FULL1 | main register valid, skid empty
// ST_FULL2 | main and skid valid (SKID=1 only), upstream stalled
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int CTRL_W   = PIPE_CTRL_W,
  parameter int DATA_W   = PIPE_DATA_W,
  parameter int SKID     = 1,
  parameter int CLR_DATA = 1,
  parameter int CNT_W    = PIPE_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  occ_state_t        state_q, state_d;
  logic              load_main, load_skid, main_from_skid;
  logic              in_xfer, out_xfer;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;

  assign out_valid = (state_q != ST_EMPTY);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          state_d   = ST_FULL1;
          load_main = 1'b1;
        end
      end
      ST_FULL1: begin
        if (out_xfer && in_xfer) begin
          load_main = 1'b1;
        end else if (out_xfer) begin
          state_d = ST_EMPTY;
        end else if (in_xfer && (SKID != 0)) begin
          // Only reachable with a skid: without one, in_ready in FULL1
          // implies out_ready, so the first branch has already fired.
          state_d   = ST_FULL2;
          load_skid = 1'b1;
        end
      end
      ST_FULL2: begin
        if (out_xfer) begin
          state_d        = ST_FULL1;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      main_ctrl <= '0;
      if (CLR_DATA != 0) main_data <= '0;
    end else if (main_from_skid) begin
      main_ctrl <= skid_ctrl;
      main_data <= skid_data;
    end else if (load_main) begin
      main_ctrl <= in_ctrl;
      main_data <= in_data;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      // Ready depends only on the state register, never on out_ready.
      assign in_ready = (state_q != ST_FULL2);

      always_ff @(posedge clk) begin
        if (reset || flush) begin
          skid_ctrl <= '0;
          if (CLR_DATA != 0) skid_data <= '0;
        end else if (load_skid) begin
          skid_ctrl <= in_ctrl;
          skid_data <= in_data;
        end
      end
    end else begin : g_noskid
      logic load_skid_unused;
      assign load_skid_unused = load_skid;
      assign in_ready  = out_ready || !out_valid;
      assign skid_ctrl = '0;
      assign skid_data = '0;
    end
  endgenerate

  // Gate control so a bubble can never write the register file or memory.
  assign out_ctrl = out_valid ? main_ctrl : '0;
  assign out_data = main_data;

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (1'b0),
    .inc   (!out_valid),
    .count (bubble_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (1'b0),
    .inc   (out_valid && !out_ready),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  localparam int CW = 8;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // DUT A: skid buffer, 4-bit counters
  logic          a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [CW-1:0] a_in_ctrl, a_out_ctrl;
  logic [DW-1:0] a_in_data, a_out_data;
  logic [3:0]    a_bubble, a_stall;

  // DUT B: no skid, combinational ready
  logic          b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [CW-1:0] b_in_ctrl, b_out_ctrl;
  logic [DW-1:0] b_in_data, b_out_data;
  logic [15:0]   b_bubble, b_stall;

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CLR_DATA(1), .CNT_W(4)) u_dut_a (
    .clk(clk), .reset(reset), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_ctrl(a_in_ctrl), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ctrl(a_out_ctrl), .out_data(a_out_data),
    .bubble_cnt(a_bubble), .stall_cnt(a_stall)
  );

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CLR_DATA(1), .CNT_W(16)) u_dut_b (
    .clk(clk), .reset(reset), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ctrl(b_in_ctrl), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ctrl(b_out_ctrl), .out_data(b_out_data),
    .bubble_cnt(b_bubble), .stall_cnt(b_stall)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [CW+DW-1:0] a_q[$];
  logic [CW+DW-1:0] b_q[$];

  // Scoreboards: transfers are decided at the next rising edge, so the
  // falling edge sees settled handshakes. Pop before push: an entry
  // accepted this cycle cannot leave in the same cycle.
  always @(negedge clk) begin
    if (reset || a_flush) begin
      a_q.delete();
    end else begin
      if (!a_out_valid) check("a_bubble_ctrl", 32'(a_out_ctrl), 32'h0);
      if (a_out_valid && a_out_ready) begin
        if (a_q.size() == 0) check("a_extra_entry", 32'(a_q.size()), 32'd1);
        else check("a_order", 32'({a_out_ctrl, a_out_data}), 32'(a_q.pop_front()));
      end
      if (a_in_valid && a_in_ready) a_q.push_back({a_in_ctrl, a_in_data});
    end
  end

  always @(negedge clk) begin
    if (reset || b_flush) begin
      b_q.delete();
    end else begin
      if (!b_out_valid) check("b_bubble_ctrl", 32'(b_out_ctrl), 32'h0);
      if (b_out_valid && b_out_ready) begin
        if (b_q.size() == 0) check("b_extra_entry", 32'(b_q.size()), 32'd1);
        else check("b_order", 32'({b_out_ctrl, b_out_data}), 32'(b_q.pop_front()));
      end
      if (b_in_valid && b_in_ready) b_q.push_back({b_in_ctrl, b_in_data});
    end
  end

  task automatic a_push(input logic [CW-1:0] c, input logic [DW-1:0] d);
    a_in_valid = 1'b1;
    a_in_ctrl  = c;
    a_in_data  = d;
    step();
    a_in_valid = 1'b0;
  endtask

  initial begin
    int idx;
    logic xfer;
    reset = 1'b1;
    a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0; a_in_ctrl = '0; a_in_data = '0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_ctrl = '0; b_in_data = '0;

    // reset state
    step(); step();
    check("rst_in_ready", 32'(a_in_ready), 32'd1);
    check("rst_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_out_ctrl", 32'(a_out_ctrl), 32'd0);
    check("rst_out_data", 32'(a_out_data), 32'd0);
    check("rst_bubble", 32'(a_bubble), 32'd0);
    check("rst_stall", 32'(a_stall), 32'd0);
    reset = 1'b0;

    // saturation: 20 idle cycles on a 4-bit counter
    for (int i = 0; i < 20; i++) step();
    check("sat_bubble", 32'(a_bubble), 32'd15);
    step(); step(); step();
    check("sat_hold", 32'(a_bubble), 32'd15);

    // streaming, one cycle latency
    a_out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      a_in_valid = 1'b1;
      a_in_ctrl  = CW'(i * 3);
      a_in_data  = DW'(i);
      step();
      check("stream_valid", 32'(a_out_valid), 32'd1);
      check("stream_data", 32'(a_out_data), 32'(i));
      check("stream_ctrl", 32'(a_out_ctrl), 32'(CW'(i * 3)));
      check("stream_in_ready", 32'(a_in_ready), 32'd1);
    end
    a_in_valid = 1'b0;
    step(); step();
    check("stream_stall", 32'(a_stall), 32'd0);
    check("stream_drained", 32'(a_out_valid), 32'd0);

    // back-pressure into FULL2
    a_out_ready = 1'b0;
    a_push(8'h01, 16'h11);
    check("bp_full1_ready", 32'(a_in_ready), 32'd1);
    a_push(8'h02, 16'h22);
    check("bp_full2_ready", 32'(a_in_ready), 32'd0);
    check("bp_head", 32'(a_out_data), 32'h11);
    step();
    check("bp_hold_data", 32'(a_out_data), 32'h11);
    check("bp_hold_ctrl", 32'(a_out_ctrl), 32'h01);
    check("bp_stall_cnt", 32'(a_stall), 32'd2);
    a_out_ready = 1'b1;
    step();
    check("bp_second", 32'(a_out_data), 32'h22);
    check("bp_ready_back", 32'(a_in_ready), 32'd1);
    step();
    check("bp_empty", 32'(a_out_valid), 32'd0);

    // flush from FULL2 with an incoming entry
    a_out_ready = 1'b0;
    a_push(8'h03, 16'h33);
    a_push(8'h04, 16'h44);
    a_flush = 1'b1; a_in_valid = 1'b1; a_in_ctrl = 8'hFF; a_in_data = 16'h55;
    step();
    a_flush = 1'b0; a_in_valid = 1'b0;
    check("fl_out_valid", 32'(a_out_valid), 32'd0);
    check("fl_out_ctrl", 32'(a_out_ctrl), 32'd0);
    check("fl_out_data", 32'(a_out_data), 32'd0);
    check("fl_in_ready", 32'(a_in_ready), 32'd1);
    check("fl_stall_kept", 32'(a_stall), 32'd4);
    a_out_ready = 1'b1;
    step(); step();

    // flush from FULL1 drops a simultaneous in-transfer
    a_out_ready = 1'b0;
    a_push(8'h06, 16'h66);
    a_flush = 1'b1; a_in_valid = 1'b1; a_in_ctrl = 8'h07; a_in_data = 16'h77;
    step();
    a_flush = 1'b0; a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    step();
    check("fl1_dropped", 32'(a_out_valid), 32'd0);

    // reset mid-stall
    a_out_ready = 1'b0;
    a_push(8'h08, 16'h88);
    a_push(8'h09, 16'h99);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rs_out_valid", 32'(a_out_valid), 32'd0);
    check("rs_out_data", 32'(a_out_data), 32'd0);
    check("rs_bubble", 32'(a_bubble), 32'd0);
    check("rs_stall", 32'(a_stall), 32'd0);
    check("rs_in_ready", 32'(a_in_ready), 32'd1);
    a_out_ready = 1'b1;
    step(); step();
    check("a_sb_empty", 32'(a_q.size()), 32'd0);

    // SKID=0: combinational ready
    b_out_ready = 1'b0;
    b_in_valid = 1'b1; b_in_ctrl = 8'h5A; b_in_data = 16'hA1;
    step();
    b_in_valid = 1'b0;
    #1;
    check("b_ready_low", 32'(b_in_ready), 32'd0);
    b_out_ready = 1'b1;
    #1;
    check("b_ready_comb", 32'(b_in_ready), 32'd1);
    step();
    check("b_drained", 32'(b_out_valid), 32'd0);

    idx = 0;
    for (int i = 0; i < 16; i++) begin
      b_out_ready = (i % 3) != 0;
      b_in_valid  = 1'b1;
      b_in_ctrl   = CW'(idx + 8'h10);
      b_in_data   = DW'(16'hB0 + idx);
      #1;
      xfer = b_in_valid && b_in_ready;
      step();
      if (xfer) idx++;
    end
    b_in_valid = 1'b0;
    b_out_ready = 1'b1;
    step(); step();
    check("b_sb_empty", 32'(b_q.size()), 32'd0);
    check("b_accepted", 32'(idx > 5), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Generic parametrised pipeline stage register, successor to the fixed-field EX/MEM latch.
- Carries a control bundle and a data bundle between pipeline stages with a valid/ready handshake, flush-to-bubble, and an optional 1-entry skid buffer.
- The skid buffer lets downstream back-pressure stall the stage without a combinational ready path.
- Instantiated once per stage boundary: IF/ID, ID/EX, EX/MEM, MEM/WB.

Parameters:
- CTRL_W, 8, width of control bundle (RegWrite, MemWrite, Branch, …); forced to zero whenever the stage holds no valid entry.
- DATA_W, 96, width of data bundle (ALU result, store data, pc, …).
- SKID, 1, 1 = registered ready with 1-entry skid buffer; 0 = single register, in_ready combinational.
- CLR_DATA, 1, 1 = data bundle zeroed on reset/flush; 0 = data bundle retains stale value (control still zeroed).
- CNT_W, 16, width of the bubble/stall statistics counters.

Ports:
- clk, in, 1, clock, rising edge.
- reset, in, 1, synchronous, active-high.
- flush, in, 1, discard all held entries this edge (branch/exception).
- in_valid, in, 1, upstream entry present.
- in_ready, out, 1, stage accepts entry this cycle.
- in_ctrl, in, CTRL_W, upstream control bundle.
- in_data, in, DATA_W, upstream data bundle.
- out_valid, out, 1, stage holds a valid entry.
- out_ready, in, 1, downstream accepts entry this cycle.
- out_ctrl, out, CTRL_W, held control bundle; 0 when out_valid=0.
- out_data, out, DATA_W, held data bundle.
- bubble_cnt, out, CNT_W, saturating count of cycles with out_valid=0.
- stall_cnt, out, CNT_W, saturating count of cycles with out_valid=1 && out_ready=0.

Behaviour:
- Transfers: in-xfer = in_valid && in_ready; out-xfer = out_valid && out_ready. All state updates occur on the rising edge of clk.
- Reset (highest priority):
  - main and skid entries become invalid; out_valid=0, out_ctrl=0.
  - out_data=0 if CLR_DATA, else unchanged.
  - bubble_cnt=0, stall_cnt=0.
  - in_ready=1 during and after reset.
- Flush (next priority): same clearing of main and skid entries as reset.
  - An in-xfer in the same cycle is dropped.
  - Counters are not cleared.
  - In the cycle after flush, out_valid=0 and in_ready=1.
- Latency: 1 cycle from in-xfer to out_valid, with no stall.
- SKID=0:
  - in_ready = out_ready || !out_valid (combinational).
  - On in-xfer the main register loads in_ctrl/in_data, out_valid=1.
  - On out-xfer without in-xfer, out_valid=0.
  - Otherwise hold.
- SKID=1, states by occupancy:
  - EMPTY (main invalid): in-xfer -> FULL1.
  - FULL1 (main valid, skid invalid):
    - out-xfer && in-xfer -> FULL1 with new main.
    - out-xfer only -> EMPTY.
    - in-xfer && !out_ready -> FULL2, new entry into skid.
    - otherwise hold.
  - FULL2 (main and skid valid):
    - out-xfer -> FULL1, main <= skid.
    - otherwise hold.
  - in_ready = !skid_valid, a registered signal with no combinational dependence on out_ready.
  - in_ready is deasserted only in FULL2.
- Ordering: entries leave in arrival order; no entry is duplicated or lost except by flush/reset.
- out_ctrl is gated to 0 whenever out_valid=0, so a bubble never writes the register file or memory.
- bubble_cnt increments on each cycle with out_valid=0; stall_cnt increments on out_valid && !out_ready. Both saturate at 2^CNT_W−1 (no wrap).
- Data and ctrl are held stable while out_valid && !out_ready.

Decomposition:
- Shared package pipe_pkg holds:
  - default widths;
  - ctrl bit-index localparams for EX/MEM (CTRL_REGWRITE, CTRL_MEMTOREG, CTRL_BRANCH, CTRL_MEMWR[1:0], CTRL_MEMRD[1:0]);
  - the EX/MEM data packing offsets (aluout, busB, pc, rd).
- One sub-module sat_counter (CNT_W, inc, clear) is instantiated twice for the statistics counters.
- The skid datapath is inline, generated on SKID.

Test Plan:
- Streaming: reset 2 cycles, then in_valid=1 every cycle with in_data=1,2,3,…, out_ready=1 -> out_data=1,2,3 one cycle later each; in_ready stays 1; stall_cnt=0.
- Back-pressure (SKID=1): push A=0x11, B=0x22 with out_ready=0 -> FULL2, in_ready=0 next cycle. Then out_ready=1 -> out_data 0x11 then 0x22, no loss, in_ready=1 again.
- Flush: stage in FULL2, assert flush with in_valid=1 and in_ctrl=8'hFF -> next cycle out_valid=0, out_ctrl=0, in_ready=1; the flushed and incoming entries never appear.
- Reset mid-stall: FULL2, out_ready=0, reset=1 for 1 cycle -> out_valid=0, counters 0, out_data=0 (CLR_DATA=1).
- Saturation: CNT_W=4, idle 20 cycles -> bubble_cnt=15 and holds at 15.
- SKID=0: out_ready=0 with valid entry -> in_ready=0 in the same cycle; toggling out_ready=1 -> in_ready=1 combinationally; entries transfer 1-for-1.
